// File: rtl/sawtooth_seq_ctrl.sv
// ----------------------------------------------------------------------------
// sawtooth_seq_ctrl
// Sequencing controller for the sawtooth counter datapath. The raw V and START
// buttons are synchronised and edge-detected into one-clk events. Those events
// capture the N1/N2 bounds from the data switches and then start, pause and
// restart a sawtooth count. The count steps once per divider tick.
//
// Ports
//   clk_i      system clock
//   rst_i      asynchronous, active-high reset (released synchronously upstream)
//   tick_i     one-clk step strobe from the clock divider
//   v_i        V button, raw asynchronous level
//   st_i       START button, raw asynchronous level
//   din_i      data switches, sampled only when a bound is captured
//   state_o    current FSM state code
//   n1_o       captured start bound
//   n2_o       captured end bound
//   cnt_o      sawtooth value
//   dir_o      1 = counting down (N1 > N2)
//   run_o      high while in RUN
//   wrap_o     one-clk pulse on each N2 -> N1 wrap
//   periods_o  wraps completed since last start, saturating
// ----------------------------------------------------------------------------
module sawtooth_seq_ctrl #(
    parameter int DW = 8,
    parameter int PW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          tick_i,
    input  logic          v_i,
    input  logic          st_i,
    input  logic [DW-1:0] din_i,
    output logic [2:0]    state_o,
    output logic [DW-1:0] n1_o,
    output logic [DW-1:0] n2_o,
    output logic [DW-1:0] cnt_o,
    output logic          dir_o,
    output logic          run_o,
    output logic          wrap_o,
    output logic [PW-1:0] periods_o
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD_N1 = 3'd1;
    localparam logic [2:0] S_LOAD_N2 = 3'd2;
    localparam logic [2:0] S_READY   = 3'd3;
    localparam logic [2:0] S_RUN     = 3'd4;
    localparam logic [2:0] S_PAUSE   = 3'd5;

    localparam logic [DW-1:0] CNT_ONE  = {{(DW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] PER_ONE  = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] PER_MAX  = {PW{1'b1}};

    // [0] and [1] form the two-flop synchroniser, [2] is the edge flop.
    logic [2:0]    v_sync_r;
    logic [2:0]    st_sync_r;
    logic          v_ev_s;
    logic          st_ev_s;

    logic [2:0]    state_r;
    logic [2:0]    state_next_s;

    logic [DW-1:0] n1_r, n1_next_s;
    logic [DW-1:0] n2_r, n2_next_s;
    logic [DW-1:0] cnt_r, cnt_next_s;
    logic          dir_r, dir_next_s;
    logic          run_r;
    logic          wrap_r, wrap_next_s;
    logic [PW-1:0] periods_r, periods_next_s;

    // Button synchronisers and edge-detect flops.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v_sync_r  <= 3'b000;
            st_sync_r <= 3'b000;
        end else begin
            v_sync_r  <= {v_sync_r[1:0], v_i};
            st_sync_r <= {st_sync_r[1:0], st_i};
        end
    end

    // Rising edge of the synchronised level: one clk per button press.
    assign v_ev_s  = v_sync_r[1]  & ~v_sync_r[2];
    assign st_ev_s = st_sync_r[1] & ~st_sync_r[2];

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; V always wins over START.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (v_ev_s) state_next_s = S_LOAD_N1;
                else        state_next_s = S_IDLE;
            end
            S_LOAD_N1: begin
                if (v_ev_s) state_next_s = S_LOAD_N2;
                else        state_next_s = S_LOAD_N1;
            end
            S_LOAD_N2: begin
                if (v_ev_s) state_next_s = S_READY;
                else        state_next_s = S_LOAD_N2;
            end
            S_READY: begin
                if (v_ev_s)       state_next_s = S_LOAD_N1;
                else if (st_ev_s) state_next_s = S_RUN;
                else              state_next_s = S_READY;
            end
            S_RUN: begin
                if (v_ev_s)       state_next_s = S_LOAD_N1;
                else if (st_ev_s) state_next_s = S_PAUSE;
                else              state_next_s = S_RUN;
            end
            S_PAUSE: begin
                if (v_ev_s)       state_next_s = S_LOAD_N1;
                else if (st_ev_s) state_next_s = S_RUN;
                else              state_next_s = S_PAUSE;
            end
            default: state_next_s = S_IDLE;
        endcase
    end

    // Datapath next values. A tick only steps the count when RUN is neither
    // being left nor just being entered this clk.
    always_comb begin
        n1_next_s      = n1_r;
        n2_next_s      = n2_r;
        cnt_next_s     = cnt_r;
        dir_next_s     = dir_r;
        wrap_next_s    = 1'b0;
        periods_next_s = periods_r;
        case (state_r)
            S_LOAD_N1: begin
                if (v_ev_s) n1_next_s = din_i;
                else        n1_next_s = n1_r;
            end
            S_LOAD_N2: begin
                if (v_ev_s) begin
                    n2_next_s  = din_i;
                    dir_next_s = (n1_r > din_i);
                end else begin
                    n2_next_s  = n2_r;
                end
            end
            S_READY: begin
                if (!v_ev_s && st_ev_s) begin
                    cnt_next_s     = n1_r;
                    periods_next_s = {PW{1'b0}};
                end else begin
                    cnt_next_s     = cnt_r;
                end
            end
            S_RUN: begin
                if (v_ev_s) begin
                    cnt_next_s = {DW{1'b0}};
                end else if (st_ev_s) begin
                    cnt_next_s = cnt_r;
                end else if (tick_i) begin
                    if (cnt_r == n2_r) begin
                        cnt_next_s  = n1_r;
                        wrap_next_s = 1'b1;
                        if (periods_r != PER_MAX) periods_next_s = periods_r + PER_ONE;
                        else                      periods_next_s = periods_r;
                    end else if (dir_r) begin
                        cnt_next_s = cnt_r - CNT_ONE;
                    end else begin
                        cnt_next_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    cnt_next_s = cnt_r;
                end
            end
            S_PAUSE: begin
                if (v_ev_s) cnt_next_s = {DW{1'b0}};
                else        cnt_next_s = cnt_r;
            end
            default: begin
                cnt_next_s = cnt_r;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            n1_r      <= {DW{1'b0}};
            n2_r      <= {DW{1'b0}};
            cnt_r     <= {DW{1'b0}};
            dir_r     <= 1'b0;
            run_r     <= 1'b0;
            wrap_r    <= 1'b0;
            periods_r <= {PW{1'b0}};
        end else begin
            n1_r      <= n1_next_s;
            n2_r      <= n2_next_s;
            cnt_r     <= cnt_next_s;
            dir_r     <= dir_next_s;
            run_r     <= (state_next_s == S_RUN);
            wrap_r    <= wrap_next_s;
            periods_r <= periods_next_s;
        end
    end

    assign state_o   = state_r;
    assign n1_o      = n1_r;
    assign n2_o      = n2_r;
    assign cnt_o     = cnt_r;
    assign dir_o     = dir_r;
    assign run_o     = run_r;
    assign wrap_o    = wrap_r;
    assign periods_o = periods_r;

endmodule

// File: doc/sawtooth_seq_ctrl.md
Name: sawtooth_seq_ctrl

Overview:
Sequencing controller for the sawtooth counter datapath. It turns the raw V and START buttons into single-cycle events and captures the N1/N2 bounds from the data switches. It then runs, pauses and restarts the sawtooth count, stepping once per tick strobe from the clock divider. Its outputs drive the display/LED decode in sawtooth_counter_top.

Parameters:
DW, 8, width of din_i, bounds and counter
PW, 8, width of the completed-period counter (saturating)

Ports:
clk_i  in  1  system clock (50 MHz)
rst_i  in  1  asynchronous, active-high reset
tick_i  in  1  one-clk-wide step strobe from divider (4 Hz rate)
v_i  in  1  V button, raw level, asynchronous to clk_i
st_i  in  1  START button, raw level, asynchronous to clk_i
din_i  in  DW  data switches, quasi-static, sampled only on a capture event
state_o  out  3  current FSM state code
n1_o  out  DW  captured start bound
n2_o  out  DW  captured end bound
cnt_o  out  DW  sawtooth value
dir_o  out  1  1 = counting down (N1 > N2)
run_o  out  1  high while in RUN
wrap_o  out  1  one-clk pulse on each N2 -> N1 wrap
periods_o  out  PW  wraps completed since last start, saturates at 2^PW-1

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE.
- Input conditioning: v_i and st_i each pass through a 2-flop synchronizer plus a 3rd edge flop.
  - v_ev = s2 & ~s3; st_ev likewise. Each event is one clk wide per rising button edge.
  - A button first sampled high at edge E0 acts at edge E2. Holding a button gives no repeat.
- State codes: IDLE=0, LOAD_N1=1, LOAD_N2=2, READY=3, RUN=4, PAUSE=5. Codes 6 and 7 go to IDLE on the next clk.
- IDLE:
  - v_ev -> LOAD_N1.
  - st_ev is ignored.
- LOAD_N1:
  - v_ev -> n1 <= din_i, go to LOAD_N2.
- LOAD_N2:
  - v_ev -> n2 <= din_i, dir <= (n1 > din_i), go to READY.
- READY:
  - st_ev -> RUN, cnt <= n1, periods <= 0.
  - v_ev -> LOAD_N1 (re-enter bounds).
- RUN, on tick_i:
  - if cnt == n2: cnt <= n1, wrap_o = 1 for one clk, periods += 1 (saturating).
  - else cnt <= cnt + 1 when dir = 0, cnt - 1 when dir = 1.
- RUN, other events:
  - st_ev -> PAUSE, cnt held.
  - v_ev -> LOAD_N1, cnt <= 0, periods held.
- PAUSE:
  - tick_i is ignored.
  - st_ev -> RUN, counting resumes from the held cnt; periods is not cleared.
  - v_ev -> LOAD_N1, cnt <= 0.
- Priority within one clk: v_ev > st_ev > tick_i.
  - A tick coinciding with a transition out of RUN does not step the count.
  - A tick in the same clk as entering RUN does not step; the first step is on the next tick.
- n1 == n2: cnt stays at n1, wrap_o and periods increment on every tick.
- Bounds change only in LOAD_N1/LOAD_N2. n1_o/n2_o keep their values in every other state.
- Arithmetic is unsigned DW bits. cnt never leaves the inclusive [min(n1,n2), max(n1,n2)] range, so no wrap past 0 or 2^DW-1.
- run_o = (state == RUN). dir_o is registered and updates only at the N2 capture.
- Reset mid-RUN returns to IDLE immediately. Bounds are cleared, and a full V, V, V, START sequence is needed to run again.

Test Plan:
- Reset, V, V(din=20), V(din=40), START -> state 4, cnt 20, 21, … 40, 20 on successive ticks; wrap_o pulses on the 21st tick; periods = 1.
- After 50 ticks in the first scenario, START -> PAUSE; 15 ticks leave cnt unchanged; START -> RUN resumes from the held value and periods is not reset.
- V from RUN, V(din=15)? Use instead V(din=76), V(din=15), START -> dir_o = 1, cnt 76, 75, … 15, 76; wrap at the 62nd tick.
- N1 = N2 = 9, START, 5 ticks -> cnt stays 9, five wrap_o pulses, periods = 5. With PW = 8, 300 wraps -> periods holds at 255.
- v_ev, st_ev and tick_i in the same clk while in RUN -> goes to LOAD_N1, cnt = 0, no wrap. st_ev with tick_i -> PAUSE with cnt unchanged.
- Assert rst_i mid-RUN between clk edges -> all outputs 0 at once, without waiting for a clk edge. Holding V high for 100 ticks after release yields exactly one transition (IDLE -> LOAD_N1).
